// File: rtl/dest_track_pipe.sv
// Destination tracker that rides beside the ID/EX, EX/MEM and MEM/WB registers.
// Publishes per-stage write info, a pending-write busy vector and stall/flush event counters.
module dest_track_pipe #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     idDest,
    input  logic                  idWbEn,
    input  logic                  idMemREn,
    input  logic                  idValid,
    input  logic                  hazard,
    input  logic                  flush,
    output logic [REG_AW-1:0]     destEx,
    output logic                  wbEnEx,
    output logic                  memREnEx,
    output logic [REG_AW-1:0]     destMem,
    output logic                  wbEnMem,
    output logic [REG_AW-1:0]     destWb,
    output logic                  wbEnWb,
    output logic [2**REG_AW-1:0]  busy,
    output logic [CNT_W-1:0]      stallCount,
    output logic [CNT_W-1:0]      flushCount
);
    localparam int              NREG    = 2**REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wbEn;
        logic              memREn;
    } slot_t;

    slot_t            r_ex, r_mem, r_wb, w_exNext;
    logic [CNT_W-1:0] r_stallCnt, r_flushCnt;
    logic [NREG-1:0]  w_busy;

    // A stall or a taken branch both turn the ID instruction into a bubble in EX.
    always_comb begin
        w_exNext = '0;
        if (!(flush || hazard)) begin
            w_exNext.valid  = idValid;
            w_exNext.dest   = idDest;
            w_exNext.wbEn   = idWbEn;
            w_exNext.memREn = idMemREn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_exNext;
        end
    end

    // Flush wins over hazard, so a cycle with both counts only as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (flush && r_flushCnt != CNT_MAX)
                r_flushCnt <= r_flushCnt + CNT_ONE;
            if (hazard && !flush && r_stallCnt != CNT_MAX)
                r_stallCnt <= r_stallCnt + CNT_ONE;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int r = 0; r < NREG; r++) begin
            w_busy[r] = (r_ex.valid  && r_ex.wbEn  && r_ex.dest  == REG_AW'(r)) ||
                        (r_mem.valid && r_mem.wbEn && r_mem.dest == REG_AW'(r)) ||
                        (r_wb.valid  && r_wb.wbEn  && r_wb.dest  == REG_AW'(r));
        end
    end

    assign destEx     = r_ex.dest;
    assign wbEnEx     = r_ex.valid & r_ex.wbEn;
    assign memREnEx   = r_ex.valid & r_ex.memREn;
    assign destMem    = r_mem.dest;
    assign wbEnMem    = r_mem.valid & r_mem.wbEn;
    assign destWb     = r_wb.dest;
    assign wbEnWb     = r_wb.valid & r_wb.wbEn;
    assign busy       = w_busy;
    assign stallCount = r_stallCnt;
    assign flushCount = r_flushCnt;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Directed bench for dest_track_pipe: table of per-cycle vectors plus reset, flush/hazard and saturation sequences.
module tb_dest_track_pipe;
    logic        clk, rst;
    logic [3:0]  idDest;
    logic        idWbEn, idMemREn, idValid, hazard, flush;
    logic [3:0]  destEx, destMem, destWb;
    logic        wbEnEx, memREnEx, wbEnMem, wbEnWb;
    logic [15:0] busy;
    logic [3:0]  stallCount, flushCount;

    int nchk = 0;
    int nerr = 0;

    dest_track_pipe #(.REG_AW(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .idDest(idDest), .idWbEn(idWbEn), .idMemREn(idMemREn), .idValid(idValid),
        .hazard(hazard), .flush(flush),
        .destEx(destEx), .wbEnEx(wbEnEx), .memREnEx(memREnEx),
        .destMem(destMem), .wbEnMem(wbEnMem),
        .destWb(destWb), .wbEnWb(wbEnWb),
        .busy(busy), .stallCount(stallCount), .flushCount(flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs: dest wb mr v hz fl | expected: dEx wEx mEx dMem wMem dWb wWb busy st fl
    typedef struct {
        int d, wb, mr, v, hz, fl;
        int dEx, wEx, mEx, dMem, wMem, dWb, wWb, bsy, st, fc;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(string nm, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int dEx, int wEx, int mEx, int dMem, int wMem,
                           int dWb, int wWb, int bsy, int st, int fc);
        chk({tag, ".destEx"},     int'(destEx),     dEx);
        chk({tag, ".wbEnEx"},     int'(wbEnEx),     wEx);
        chk({tag, ".memREnEx"},   int'(memREnEx),   mEx);
        chk({tag, ".destMem"},    int'(destMem),    dMem);
        chk({tag, ".wbEnMem"},    int'(wbEnMem),    wMem);
        chk({tag, ".destWb"},     int'(destWb),     dWb);
        chk({tag, ".wbEnWb"},     int'(wbEnWb),     wWb);
        chk({tag, ".busy"},       int'(busy),       bsy);
        chk({tag, ".stallCount"}, int'(stallCount), st);
        chk({tag, ".flushCount"}, int'(flushCount), fc);
    endtask

    task automatic drive(int d, int wb, int mr, int v, int hz, int fl);
        idDest   = 4'(d);
        idWbEn   = 1'(wb);
        idMemREn = 1'(mr);
        idValid  = 1'(v);
        hazard   = 1'(hz);
        flush    = 1'(fl);
    endtask

    // Short reset pulse placed between clock edges.
    task automatic rst_pulse();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3,1,0,1,0,0,  3,1,0, 0,0, 0,0, 'h0008, 0,0};
        tbl[1]  = '{5,1,0,1,0,0,  5,1,0, 3,1, 0,0, 'h0028, 0,0};
        tbl[2]  = '{7,1,0,1,0,0,  7,1,0, 5,1, 3,1, 'h00A8, 0,0};
        tbl[3]  = '{0,0,0,0,0,0,  0,0,0, 7,1, 5,1, 'h00A0, 0,0};
        tbl[4]  = '{0,0,0,0,0,0,  0,0,0, 0,0, 7,1, 'h0080, 0,0};
        tbl[5]  = '{0,0,0,0,0,0,  0,0,0, 0,0, 0,0, 'h0000, 0,0};
        tbl[6]  = '{4,1,1,1,1,0,  0,0,0, 0,0, 0,0, 'h0000, 1,0};
        tbl[7]  = '{9,1,0,1,1,1,  0,0,0, 0,0, 0,0, 'h0000, 1,1};
        tbl[8]  = '{4,1,1,1,0,0,  4,1,1, 0,0, 0,0, 'h0010, 1,1};
        tbl[9]  = '{6,1,1,0,0,0,  6,0,0, 4,1, 0,0, 'h0010, 1,1};
        tbl[10] = '{1,1,0,1,0,1,  0,0,0, 6,0, 4,1, 'h0010, 1,2};
        tbl[11] = '{2,1,0,1,0,0,  2,1,0, 0,0, 6,0, 'h0004, 1,2};
        tbl[12] = '{2,1,0,1,0,0,  2,1,0, 2,1, 0,0, 'h0004, 1,2};
        tbl[13] = '{0,0,0,0,0,0,  0,0,0, 2,1, 2,1, 'h0004, 1,2};
        tbl[14] = '{0,0,0,0,0,0,  0,0,0, 0,0, 2,1, 'h0004, 1,2};
        tbl[15] = '{0,0,0,0,0,0,  0,0,0, 0,0, 0,0, 'h0000, 1,2};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0,0,0, 0,0, 0,0, 0, 0,0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].d, tbl[i].wb, tbl[i].mr, tbl[i].v, tbl[i].hz, tbl[i].fl);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].dEx, tbl[i].wEx, tbl[i].mEx,
                    tbl[i].dMem, tbl[i].wMem, tbl[i].dWb, tbl[i].wWb,
                    tbl[i].bsy, tbl[i].st, tbl[i].fc);
        end

        // Mid-stream reset with three writes in flight and non-zero counters.
        drive(3, 1, 0, 1, 0, 0); @(posedge clk); #1;
        drive(5, 1, 0, 1, 0, 0); @(posedge clk); #1;
        drive(7, 1, 0, 1, 0, 0); @(posedge clk); #1;
        chk("inflight.busy", int'(busy), 'h00A8);
        #1;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 0,0,0, 0,0, 0,0, 0, 0,0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("rst_after", 0,0,0, 0,0, 0,0, 0, 0,0);

        // Hazard and flush together: one bubble, only the flush counter moves.
        drive(9, 1, 0, 1, 1, 1);
        @(posedge clk); #1;
        chk_all("fl_hz", 0,0,0, 0,0, 0,0, 0, 0,1);

        // Stall counter saturation at 4'hF.
        rst_pulse();
        drive(1, 1, 0, 1, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_sat%0d", i), int'(stallCount), (i > 15) ? 15 : i);
        end
        chk("stall_sat.flushCount", int'(flushCount), 0);
        chk("stall_sat.busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
